// File: rtl/dmu_arbiter.sv
// dmu_arbiter: round-robin two-port arbiter and access sequencer in front of the
// single data-memory unit port. Plain memory accesses spend one ACCESS cycle;
// accesses to the I/O page are stretched to IO_WAIT ACCESS cycles.
module dmu_arbiter #(
    parameter int          ADDR_W  = 16,
    parameter int          DATA_W  = 32,
    parameter logic [7:0]  IO_PAGE = 8'hFF,
    parameter int          IO_WAIT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              dmu_rd,
    output logic              dmu_we,
    output logic [ADDR_W-1:0] dmu_addr,
    output logic [DATA_W-1:0] dmu_din,
    input  logic [DATA_W-1:0] dmu_dout,
    output logic              busy,
    output logic              gnt_id
);

    // wait_cnt load value for an I/O access; the counter runs down to zero inclusive
    localparam logic [3:0] WAIT_IO = 4'(IO_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic                   last_gnt;
    logic                   gnt_q;
    logic                   we_q;
    logic                   first_q;
    logic [3:0]             wait_cnt;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [1:0][DATA_W-1:0] rdata_q;

    logic                   any_req;
    logic                   win;
    logic                   win_we;
    logic [ADDR_W-1:0]      win_addr;
    logic [DATA_W-1:0]      win_wdata;

    // round-robin pick: a lone requester wins, on a tie the port that lost last time goes
    always_comb begin
        any_req   = p0_req | p1_req;
        win       = (p0_req & p1_req) ? ~last_gnt : p1_req;
        win_we    = win ? p1_we    : p0_we;
        win_addr  = win ? p1_addr  : p0_addr;
        win_wdata = win ? p1_wdata : p0_wdata;
    end

    // next-state logic: IDLE -> ACCESS (until wait_cnt hits zero) -> RESP -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (wait_cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // latch the winner's request at grant and count down the ACCESS cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_gnt <= 1'b1;
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            first_q  <= 1'b0;
            wait_cnt <= 4'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (state == IDLE && any_req) begin
            last_gnt <= win;
            gnt_q    <= win;
            we_q     <= win_we;
            first_q  <= 1'b1;
            addr_q   <= win_addr;
            wdata_q  <= win_wdata;
            wait_cnt <= (win_addr[ADDR_W-1 -: 8] == IO_PAGE) ? WAIT_IO : 4'd0;
        end else if (state == ACCESS) begin
            first_q <= 1'b0;
            if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // read data is taken on the last ACCESS cycle; the other port's register is untouched
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            rdata_q <= '0;
        else if (state == ACCESS && wait_cnt == 4'd0 && !we_q)
            rdata_q[gnt_q] <= dmu_dout;
    end

    // rd is held for the whole stretched access; we only on the first cycle so an
    // I/O device sees exactly one write strobe
    assign dmu_rd   = (state == ACCESS) & ~we_q;
    assign dmu_we   = (state == ACCESS) & we_q & first_q;
    assign dmu_addr = addr_q;
    assign dmu_din  = wdata_q;

    assign busy     = (state != IDLE);
    assign gnt_id   = gnt_q;
    assign p0_ack   = (state == RESP) & ~gnt_q;
    assign p1_ack   = (state == RESP) &  gnt_q;
    assign p0_rdata = rdata_q[0];
    assign p1_rdata = rdata_q[1];

endmodule

// File: tb/tb_dmu_arbiter.sv
// tb_dmu_arbiter: directed scenarios plus randomized two-port traffic, checked every
// cycle against a transaction-level reference model of the arbiter.
module tb_dmu_arbiter;

    localparam int IOW = 3;

    logic        clk;
    logic        rstn;
    logic        p0_req, p0_we, p0_ack;
    logic [15:0] p0_addr;
    logic [31:0] p0_wdata, p0_rdata;
    logic        p1_req, p1_we, p1_ack;
    logic [15:0] p1_addr;
    logic [31:0] p1_wdata, p1_rdata;
    logic        dmu_rd, dmu_we, busy, gnt_id;
    logic [15:0] dmu_addr;
    logic [31:0] dmu_din, dmu_dout;
    logic [31:0] io_reg;

    int checks   = 0;
    int failures = 0;

    dmu_arbiter #(.ADDR_W(16), .DATA_W(32), .IO_PAGE(8'hFF), .IO_WAIT(IOW)) dut (
        .clk(clk), .rstn(rstn),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .dmu_rd(dmu_rd), .dmu_we(dmu_we), .dmu_addr(dmu_addr), .dmu_din(dmu_din),
        .dmu_dout(dmu_dout), .busy(busy), .gnt_id(gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (i == 16) ? 32'hDEADBEEF : {b, 8'hC3, ~b, 8'h3C};
    endfunction

    // memory device behind the arbiter; the FF page is an I/O register instead
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_pat(i);
        end else if (dmu_we && dmu_addr[15:8] != 8'hFF) begin
            mem[dmu_addr[7:0]] <= dmu_din;
        end
    end
    assign dmu_dout = (dmu_addr[15:8] == 8'hFF) ? io_reg : mem[dmu_addr[7:0]];

    // ---------------- reference model (transaction level) ----------------
    // m_pos: 0 = no transaction; 1..m_len = access cycle index; m_len+1 = response cycle
    int          m_pos = 0;
    int          m_len = 1;
    logic        m_port = 1'b0, m_we = 1'b0, m_last = 1'b1, m_gnt = 1'b0;
    logic [15:0] m_addr = '0;
    logic [31:0] m_din = '0;
    logic [31:0] m_rdata [2];
    logic [31:0] model_mem [256];

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic acc, rsp, io, w;
        if (!rstn) begin
            chk1("rst_busy", busy, 1'b0);     chk1("rst_rd", dmu_rd, 1'b0);
            chk1("rst_we", dmu_we, 1'b0);     chk1("rst_ack0", p0_ack, 1'b0);
            chk1("rst_ack1", p1_ack, 1'b0);   chk1("rst_gnt", gnt_id, 1'b0);
            chk32("rst_addr", {16'h0, dmu_addr}, 32'h0);
            chk32("rst_din", dmu_din, 32'h0);
            chk32("rst_rdata0", p0_rdata, 32'h0);
            chk32("rst_rdata1", p1_rdata, 32'h0);
            m_pos = 0; m_last = 1'b1; m_gnt = 1'b0; m_we = 1'b0;
            m_addr = '0; m_din = '0; m_rdata[0] = '0; m_rdata[1] = '0;
            for (int i = 0; i < 256; i++) model_mem[i] = init_pat(i);
            return;
        end
        acc = (m_pos >= 1 && m_pos <= m_len);
        rsp = (m_pos != 0 && m_pos == m_len + 1);
        chk1("busy", busy, m_pos != 0);
        chk1("dmu_rd", dmu_rd, acc && !m_we);
        chk1("dmu_we", dmu_we, m_pos == 1 && m_we);
        chk32("dmu_addr", {16'h0, dmu_addr}, {16'h0, m_addr});
        chk32("dmu_din", dmu_din, m_din);
        chk1("gnt_id", gnt_id, m_gnt);
        chk1("p0_ack", p0_ack, rsp && !m_port);
        chk1("p1_ack", p1_ack, rsp && m_port);
        chk32("p0_rdata", p0_rdata, m_rdata[0]);
        chk32("p1_rdata", p1_rdata, m_rdata[1]);
        // advance by one cycle using the inputs visible now
        io = (m_addr[15:8] == 8'hFF);
        if (m_pos == 0) begin
            if (p0_req || p1_req) begin
                w = (p0_req && p1_req) ? !m_last : p1_req;
                m_port = w; m_gnt = w; m_last = w;
                m_we   = w ? p1_we : p0_we;
                m_addr = w ? p1_addr : p0_addr;
                m_din  = w ? p1_wdata : p0_wdata;
                m_len  = (m_addr[15:8] == 8'hFF) ? IOW : 1;
                m_pos  = 1;
            end
        end else if (acc) begin
            if (m_pos == 1 && m_we && !io) model_mem[m_addr[7:0]] = m_din;
            if (m_pos == m_len && !m_we) m_rdata[m_port] = io ? io_reg : model_mem[m_addr[7:0]];
            m_pos++;
        end else begin
            m_pos = 0;
        end
    endtask

    // drive point (just after the rising edge) and sample point (falling edge)
    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
        model_step();
    endtask

    // single request from one port; lat counts cycles from the IDLE cycle that sees req
    task automatic do_access(input logic p, input logic w, input logic [15:0] a,
                             input logic [31:0] d, input logic io_seq,
                             output int lat, output int stb_n, output int acc_n);
        drv();
        if (p) begin p1_req = 1'b1; p1_we = w; p1_addr = a; p1_wdata = d; end
        else   begin p0_req = 1'b1; p0_we = w; p0_addr = a; p0_wdata = d; end
        lat = -1; stb_n = 0; acc_n = 0;
        for (int n = 0; n < 20 && lat < 0; n++) begin
            if (n > 0) drv();
            if (io_seq) io_reg = (n >= 2) ? 32'd9 : 32'd5;
            half();
            if (dmu_rd || dmu_we) stb_n++;
            if (busy && !p0_ack && !p1_ack && dmu_addr == a) acc_n++;
            if (p ? p1_ack : p0_ack) lat = n;
        end
        drv();
        if (p) p1_req = 1'b0; else p0_req = 1'b0;
        half();
    endtask

    task automatic rand_fields(output logic w, output logic [15:0] a, output logic [31:0] d);
        w = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) a = {8'hFF, 8'($urandom)};
        else                           a = {8'($urandom_range(0, 254)), 8'($urandom)};
        d = $urandom;
    endtask

    int lat, stb_n, acc_n, k;
    int order [6];

    initial begin
        rstn = 1'b0; io_reg = 32'h0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0000; p0_wdata = 32'h0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0004; p1_wdata = 32'h0;

        // 1: reset with both requesting, port 0 wins the first tie
        half();
        chk1("t1_busy_rst", busy, 1'b0);
        chk1("t1_ack0_rst", p0_ack, 1'b0);
        drv(); rstn = 1'b1; half();
        drv(); half();
        chk1("t1_gnt0", gnt_id, 1'b0);
        chk1("t1_busy", busy, 1'b1);
        drv(); p1_req = 1'b0; half();
        chk1("t1_ack0", p0_ack, 1'b1);
        drv(); p0_req = 1'b0; half();

        // 2: memory read
        do_access(1'b0, 1'b0, 16'h0010, 32'h0, 1'b0, lat, stb_n, acc_n);
        chki("t2_latency", lat, 2);
        chki("t2_rd_cycles", stb_n, 1);
        chk32("t2_rdata", p0_rdata, 32'hDEADBEEF);

        // 3: I/O write stretched to IOW cycles, single strobe
        do_access(1'b1, 1'b1, 16'hFF04, 32'h0000005A, 1'b0, lat, stb_n, acc_n);
        chki("t3_latency", lat, 4);
        chki("t3_we_cycles", stb_n, 1);
        chki("t3_addr_cycles", acc_n, 3);

        // 4: continuous contention alternates grants, acks go to the owner only
        drv();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0030;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0040;
        half();
        k = 0;
        for (int n = 0; n < 40 && k < 6; n++) begin
            drv(); half();
            chk1("t4_ack_exclusive", p0_ack & p1_ack, 1'b0);
            if (p0_ack) begin order[k] = 0; k++; end
            else if (p1_ack) begin order[k] = 1; k++; end
        end
        drv(); p0_req = 1'b0; p1_req = 1'b0; half();
        chki("t4_grants", k, 6);
        for (int i = 0; i < 6; i++) chki("t4_order", (i < k) ? order[i] : -1, i % 2);
        chk32("t4_rdata0", p0_rdata, init_pat(16'h30));
        chk32("t4_rdata1", p1_rdata, init_pat(16'h40));

        // 5: I/O read samples the device on the last ACCESS cycle
        do_access(1'b0, 1'b0, 16'hFF00, 32'h0, 1'b1, lat, stb_n, acc_n);
        chki("t5_latency", lat, 4);
        chk32("t5_rdata", p0_rdata, 32'd9);

        // 6: reset in the middle of an I/O access
        drv(); p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'hFF00; half();
        drv(); half();
        chk1("t6_in_access", dmu_rd, 1'b1);
        drv(); rstn = 1'b0; half();
        chk1("t6_rd_dropped", dmu_rd, 1'b0);
        chk1("t6_busy_dropped", busy, 1'b0);
        chk1("t6_no_ack", p0_ack, 1'b0);
        drv(); rstn = 1'b1; p0_addr = 16'h0060;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0050; half();
        drv(); half();
        chk1("t6_gnt_after_rst", gnt_id, 1'b0);
        drv(); p1_req = 1'b0; half();
        chk1("t6_ack0", p0_ack, 1'b1);
        drv(); p0_req = 1'b0; half();

        // randomized traffic from both ports with occasional resets
        for (int c = 0; c < 3000; c++) begin
            drv();
            io_reg = $urandom;
            if (!rstn) rstn = 1'b1;
            else if ($urandom_range(0, 399) == 0) begin
                rstn = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
            end
            if (rstn) begin
                if (p0_ack) p0_req = 1'b0;
                else if (!p0_req && $urandom_range(0, 2) == 0) begin
                    rand_fields(p0_we, p0_addr, p0_wdata); p0_req = 1'b1;
                end
                if (p1_ack) p1_req = 1'b0;
                else if (!p1_req && $urandom_range(0, 2) == 0) begin
                    rand_fields(p1_we, p1_addr, p1_wdata); p1_req = 1'b1;
                end
            end
            half();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
